// File: rtl/gate_sequencer.sv
// Sequencer that sweeps all four input vectors of an external 2-input gate,
// samples its output after a programmable settle time and scores it against a latched truth table.
module gate_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       truth_table,
  output logic             a_out,
  output logic             b_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(NUM_PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        table_q, table_d;
  logic [1:0]        idx_q, idx_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [3:0]        fail_q, fail_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic [1:0]        ab_q, ab_d;

  // NOTE: every register has a reset value here because the block is small and
  // the outputs must read all-zero immediately after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      table_q    <= '0;
      idx_q      <= '0;
      pass_cnt_q <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      fail_q     <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      ab_q       <= '0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      idx_q      <= idx_d;
      pass_cnt_q <= pass_cnt_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      ab_q       <= ab_d;
    end
  end

  // NOTE: all next-state signals take their hold value first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    table_d    = table_q;
    idx_d      = idx_q;
    pass_cnt_d = pass_cnt_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fail_d     = fail_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    ab_d       = ab_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETTLE;
          table_d    = truth_table;
          err_d      = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          pass_cnt_d = '0;
          ab_d       = 2'b00;
          cnt_d      = SETTLE_LOAD;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          ab_d    = 2'b00;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        // Abort takes priority and throws away this edge's comparison.
        if (abort) begin
          state_d = S_IDLE;
          ab_d    = 2'b00;
        end else begin
          if (y_in != table_q[idx_q]) begin
            fail_d[idx_q] = 1'b1;
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
          end
          if (idx_q == 2'd3 && pass_cnt_q == LAST_PASS) begin
            state_d = S_DONE;
            ab_d    = 2'b00;
          end else begin
            idx_d   = idx_q + 2'd1;
            ab_d    = idx_q + 2'd1;
            cnt_d   = SETTLE_LOAD;
            state_d = S_SETTLE;
            if (idx_q == 2'd3) pass_cnt_d = pass_cnt_q + PASS_W'(1);
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign a_out     = ab_q[1];
  assign b_out     = ab_q[0];
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
